// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder.
// The master drives the request and operands; the slave returns status and result.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             START;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CIN;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] S;
    logic             COUT;

    modport master (
        output START, A, B, CIN,
        input  BUSY, DONE, S, COUT
    );

    modport slave (
        input  START, A, B, CIN,
        output BUSY, DONE, S, COUT
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice (two half adders) plus a
// carry flop, consuming one operand bit per clock, LSB first.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for START; result registers hold the last result
// ST_RUN  | one sum bit per cycle; BUSY high
// ST_DONE | single-cycle DONE pulse; may accept a new START immediately

module half_adder (
    input  logic a,
    input  logic b,
    output logic c,
    output logic s
);
    assign c = a & b;
    assign s = a ^ b;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           CLK,
    input  logic           RST,
    serial_adder_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             accept;
    logic             last_bit;

    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_next;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] s_q;
    logic             cout_q;

    logic             c1;
    logic             s1;
    logic             c2;
    logic             sum_bit;
    logic             carry_next;

    half_adder u_ha1 (.a(sa_q[0]), .b(sb_q[0]), .c(c1), .s(s1));
    half_adder u_ha2 (.a(s1),      .b(carry_q), .c(c2), .s(sum_bit));

    assign carry_next = c1 | c2;

    // New sum bit enters at the MSB; the WIDTH=1 case has no lower bits to keep.
    generate
        if (WIDTH == 1) begin : g_sr_one
            assign sr_next = sum_bit;
        end else begin : g_sr_multi
            assign sr_next = {sum_bit, sr_q[WIDTH-1:1]};
        end
    endgenerate

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; START is only honoured in IDLE and DONE.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        last_bit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.START) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt_q == LAST_BIT) begin
                    last_bit = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.START) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Operand shifters, carry flop, bit counter and result registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
        end else if (accept) begin
            sa_q    <= bus.A;
            sb_q    <= bus.B;
            sr_q    <= '0;
            carry_q <= bus.CIN;
            cnt_q   <= '0;
        end else if (state_q == ST_RUN) begin
            sa_q    <= sa_q >> 1;
            sb_q    <= sb_q >> 1;
            sr_q    <= sr_next;
            carry_q <= carry_next;
            cnt_q   <= cnt_q + CW'(1);
            if (last_bit) begin
                s_q    <= sr_next;
                cout_q <= carry_next;
            end
        end
    end

    assign bus.BUSY = (state_q == ST_RUN);
    assign bus.DONE = (state_q == ST_DONE);
    assign bus.S    = s_q;
    assign bus.COUT = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): reset, table vectors,
// random operands against an arithmetic model, and multi-cycle corner cases.
module tb_serial_adder;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         cout;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    logic [W-1:0] prev_s;
    logic         prev_cout;
    vec_t vecs[8];

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) u_dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Arithmetic reference: {cout,s} = a + b + cin.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         output logic [W-1:0] s, output logic cout);
        int t;
        t = int'(a) + int'(b) + int'(cin);
        s = t[W-1:0];
        cout = t[W];
    endtask

    // One operation from IDLE: START for one edge, then WIDTH busy cycles,
    // a DONE cycle with the result, and a return to IDLE.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic [W-1:0] es, input logic ec, input bit interfere,
                          input string tag);
        int bad;
        bad = 0;
        bus.START = 1'b1;
        bus.A = a;
        bus.B = b;
        bus.CIN = cin;
        tick();
        bus.START = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (bus.BUSY !== 1'b1 || bus.DONE !== 1'b0 ||
                bus.S !== prev_s || bus.COUT !== prev_cout) bad++;
            bus.A = W'($urandom);
            bus.B = W'($urandom);
            bus.CIN = 1'($urandom);
            bus.START = interfere && (i == 2 || i == 3 || i == W - 1);
            tick();
        end
        bus.START = 1'b0;
        check($sformatf("%s_busy_window", tag), bad, 0);
        check($sformatf("%s_done", tag), {bus.BUSY, bus.DONE}, 2'b01);
        check($sformatf("%s_s", tag), bus.S, es);
        check($sformatf("%s_cout", tag), bus.COUT, ec);
        prev_s = es;
        prev_cout = ec;
        tick();
        check($sformatf("%s_idle_after", tag), {bus.BUSY, bus.DONE, bus.S, bus.COUT},
              {2'b00, es, ec});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] ra, rb, es;
        logic         rc, ec;
        logic [W-1:0] qa[5];
        logic [W-1:0] qb[5];
        logic         qc[5];
        int           last_done;
        int           bad;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
        vecs[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};

        // Reset held with START high must keep everything at zero.
        rst = 1'b1;
        bus.START = 1'b1;
        bus.A = 8'hFF;
        bus.B = 8'hFF;
        bus.CIN = 1'b1;
        prev_s = '0;
        prev_cout = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("reset_cycle%0d", i), {bus.BUSY, bus.DONE, bus.S, bus.COUT}, '0);
        end
        rst = 1'b0;
        bus.START = 1'b0;
        tick();
        check("reset_release", {bus.BUSY, bus.DONE, bus.S, bus.COUT}, '0);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].cout, 1'b0,
                   $sformatf("vec%0d", i));
        end

        // START re-asserted during RUN is ignored.
        run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b1, "start_in_run");

        for (int i = 0; i < 30; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            model(ra, rb, rc, es, ec);
            run_op(ra, rb, rc, es, ec, (i % 3) == 0, $sformatf("rand%0d", i));
        end

        // Back-to-back with START held high; new operands presented in each DONE cycle.
        for (int n = 0; n < 5; n++) begin
            qa[n] = W'($urandom);
            qb[n] = W'($urandom);
            qc[n] = 1'($urandom);
        end
        qa[0] = 8'hFF; qb[0] = 8'hFF; qc[0] = 1'b1;
        bus.START = 1'b1;
        bus.A = qa[0];
        bus.B = qb[0];
        bus.CIN = qc[0];
        tick();
        last_done = 0;
        for (int n = 0; n < 5; n++) begin
            bad = 0;
            for (int i = 0; i < W; i++) begin
                if (bus.BUSY !== 1'b1 || bus.DONE !== 1'b0 ||
                    bus.S !== prev_s || bus.COUT !== prev_cout) bad++;
                bus.A = W'($urandom);
                bus.B = W'($urandom);
                bus.CIN = 1'($urandom);
                tick();
            end
            model(qa[n], qb[n], qc[n], es, ec);
            check($sformatf("b2b%0d_busy_window", n), bad, 0);
            check($sformatf("b2b%0d_done", n), {bus.BUSY, bus.DONE}, 2'b01);
            check($sformatf("b2b%0d_sum", n), {bus.COUT, bus.S}, {ec, es});
            if (n > 0) check($sformatf("b2b%0d_period", n), cyc - last_done, W + 1);
            last_done = cyc;
            prev_s = es;
            prev_cout = ec;
            if (n < 4) begin
                bus.A = qa[n + 1];
                bus.B = qb[n + 1];
                bus.CIN = qc[n + 1];
            end else begin
                bus.START = 1'b0;
            end
            tick();
        end
        check("b2b_idle_after", {bus.BUSY, bus.DONE}, 2'b00);

        // Reset four cycles into RUN aborts the operation.
        bus.START = 1'b1;
        bus.A = 8'h5A;
        bus.B = 8'h3C;
        bus.CIN = 1'b0;
        tick();
        bus.START = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("abort_still_busy", bus.BUSY, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_outputs", {bus.BUSY, bus.DONE, bus.S, bus.COUT}, '0);
        prev_s = '0;
        prev_cout = 1'b0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0 || bus.S !== '0 || bus.COUT !== 1'b0) bad++;
            tick();
        end
        check("abort_no_done", bad, 0);
        run_op(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, "after_abort");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder built around two half-adder cells forming one full-adder slice plus a carry flip-flop. It accepts two operands and a carry-in on a START strobe and processes one bit per clock, LSB first. It presents the registered WIDTH-bit sum and carry-out with a one-cycle DONE pulse. It is the sequential stage that consumes the half-adder C/S outputs each cycle and feeds result registers downstream.

## Interface
- WIDTH, 8: operand and sum width in bits; legal range is WIDTH >= 1.
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  request; sampled only in IDLE or DONE.
- A  input  WIDTH  operand A; sampled on the edge that accepts START.
- B  input  WIDTH  operand B; sampled on the edge that accepts START.
- CIN  input  1  carry-in; sampled on the edge that accepts START.
- BUSY  output  1  high while in RUN.
- DONE  output  1  one-cycle pulse; S and COUT are valid from this cycle.
- S  output  WIDTH  sum result register.
- COUT  output  1  carry-out result register.

Reset is synchronous, active-high, on a single clock (CLK/RST).

## Operation
- State machine states: IDLE, RUN, DONE.
- IDLE:
  - If START is high, load A and B into shift registers SA and SB, load CIN into the carry flop, clear the bit counter, and go to RUN.
  - Otherwise stay in IDLE.
- RUN, once per cycle:
  - Half adder 1 takes SA[0] and SB[0] and produces c1 and s1.
  - Half adder 2 takes s1 and carry and produces c2 and the sum bit.
  - carry <= c1 | c2.
  - SA and SB shift right by one.
  - The sum bit enters the MSB of internal register SR, which shifts right.
  - The counter increments.
- RUN to DONE: on the edge where counter == WIDTH-1 (the last bit):
  - Final SR is copied into S.
  - Final carry is copied into COUT.
- DONE lasts exactly one cycle. Then:
  - If START is high, accept it exactly as in IDLE (back-to-back operation) and go to RUN.
  - Otherwise go to IDLE.
- START in RUN is ignored and not queued. A, B and CIN are don't-care outside the accepting edge.
- S and COUT change only on the RUN to DONE edge or on reset. They hold the previous result through IDLE and RUN.
- Arithmetic: {COUT,S} = A + B + CIN, computed exactly with no truncation. Counter width is max(1, clog2(WIDTH)).
- RST high on any edge forces:
  - state to IDLE;
  - S, COUT, BUSY and DONE to 0;
  - shift registers, carry and counter to 0.
  RST takes priority over START and over a completing operation.
- Reset in the middle of an operation aborts it: DONE does not pulse, and S/COUT read 0.

## Timing
- Reset values: S=0, COUT=0, BUSY=0, DONE=0, state IDLE.
- START is accepted on edge E0. BUSY is high from E0 until edge E0+WIDTH.
- DONE is high for the one cycle after edge E0+WIDTH, so latency is WIDTH clocks from START acceptance to DONE.
- BUSY and DONE are never high at the same time.
- WIDTH=1: RUN lasts one cycle, and DONE is high in the cycle after E0+1.
- Back-to-back operation: with START held high, throughput is one result per WIDTH+1 cycles.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Reset check: hold RST for 2 cycles with START=1 -> S=0x00, COUT=0, BUSY=0, DONE=0 throughout reset and on the first cycle after it.
- WIDTH=8, A=0x5A, B=0x3C, CIN=0, START pulse -> BUSY high for 8 cycles, then DONE pulses once with S=0x96, COUT=0.
- A=0xFF, B=0x01, CIN=0 -> S=0x00, COUT=1. Then A=0xFF, B=0xFF, CIN=1 -> S=0xFF, COUT=1.
- START re-asserted during RUN with different operands -> ignored. Original result is delivered at the original DONE cycle, and S holds the prior value until that cycle.
- START held high continuously with operands changing each DONE cycle -> DONE pulses every 9 cycles, each result matching its accepted operands.
- RST asserted 4 cycles into RUN -> no DONE pulse. S=0x00, COUT=0, return to IDLE. The next START completes correctly.
